moving_average_filter: RTL
==========================

Name: moving_average_filter

Overview:
- Streaming N-tap boxcar (moving-average) low-pass filter for signed 24-bit audio samples.
- Sits directly downstream of the ROM tone generator and the codec input path, and upstream of the codec output.
- Consumes one sample per in_valid strobe, the same strobe that advances the tone ROM address.
- Produces the floor average of the most recent N samples, registered.

Parameters:
- DATA_W, 24: sample width, two's complement.
- LOG2_N, 3: log2 of tap count; N = 2**LOG2_N = 8 by default. Legal range 1..6.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  one-cycle strobe; in_data is a new sample this cycle.
- in_data  input  DATA_W  signed input sample.
- out_valid  output  1  one-cycle pulse; out_data updated this cycle.
- out_data  output  DATA_W  signed moving average, held between updates.
- primed  output  1  high once N samples have been accepted since reset.

Behaviour:
- Reset: applies on the clk edge with reset=1 and has priority over in_valid that cycle. It sets:
  - acc=0, wr_ptr=0, fill count=0
  - out_data=0, out_valid=0, primed=0
  - The sample buffer (N x DATA_W circular RAM/regs) is not cleared; the fill count masks stale entries.
- State (encoded by the primed flag):
  - FILL: count<N. The evicted ("oldest") value is forced to 0.
  - RUN: count==N. The evicted value is buf[wr_ptr].
  - FILL->RUN on the accept that makes count==N. Only reset returns the block to FILL.
- Accept (in_valid=1, reset=0), all updates on the same edge:
  - buf[wr_ptr] <= in_data.
  - wr_ptr <= wr_ptr+1, wrapping naturally mod N.
  - acc <= acc + sext(in_data) - sext(oldest), where oldest is read before the overwrite.
  - count <= min(count+1, N).
- Arithmetic:
  - acc is signed, DATA_W+LOG2_N bits wide. It holds the exact sum of N samples; no overflow is possible.
  - Output = (next acc) >>> LOG2_N, an arithmetic shift (floor toward -inf), truncated to DATA_W. The result always fits.
- Latency: out_data and out_valid are registered on the same edge that accepts the sample.
  - out_valid=1 for exactly that cycle, 0 otherwise.
  - out_data reflects the sum including the sample just accepted.
- No accept: acc, buffer, pointers and out_data hold; out_valid=0.
- Back-to-back in_valid on consecutive cycles: fully supported, one output per input, no stalls or backpressure.
- During FILL the output is sum/N over the samples received so far (a ramp-in), not sum/count.
- primed goes high on the edge that accepts the Nth sample and stays high until reset.
- Reset mid-stream: the next output after reset is in_data>>>LOG2_N, computed as if the filter were empty.
- Implementation limits: single clock domain, no multipliers or dividers, purely shift and add/subtract.

Test Plan:
- Step response: reset, then 8 strobes of in_data=800 -> out_data 100,200,...,800; primed rises with the 8th output; further 800 inputs keep out_data=800.
- Negative step and floor: 8 strobes of -8 -> out_data -1,-2,...,-8; then a single 7 after reset -> 0, and a single -7 after reset -> -1.
- Window wrap: inputs 1..16 back-to-back -> 16th output = floor((9+...+16)/8) = 12; the 9th output = floor((2+...+9)/8) = 5.
- Extremes: 8 x 8388607 then 8 x -8388608 -> outputs reach 8388607, then reach -8388608 after 8 more inputs, with no wraparound glitch.
- Gapped strobes: in_valid every 5th cycle with 400 -> out_valid exactly on the strobe cycles; out_data holds constant between strobes; values 50,100,...,400.
- Reset mid-operation: after primed with 800, assert reset for 1 cycle coincident with in_valid -> that sample is ignored; out_data=0 and primed=0; next input 800 -> out_data=100.

Source files
------------

// File: rtl/moving_average_filter.sv
// Streaming N-tap boxcar (moving-average) filter for signed audio samples.
// Keeps a running sum of the last N samples in a circular buffer and emits
// the floor average, registered, on the same edge that accepts each sample.
module moving_average_filter #(
  parameter int DATA_W = 24,
  parameter int LOG2_N = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     primed
);

  localparam int N     = 1 << LOG2_N;
  localparam int ACC_W = DATA_W + LOG2_N;
  localparam int CNT_W = LOG2_N + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                    state;
  logic [LOG2_N-1:0]         wr_ptr;
  logic [CNT_W-1:0]          count;
  logic signed [ACC_W-1:0]   acc;
  logic signed [DATA_W-1:0]  sample_buf [N];

  logic signed [DATA_W-1:0]  oldest;
  logic signed [ACC_W-1:0]   in_ext;
  logic signed [ACC_W-1:0]   oldest_ext;
  logic signed [ACC_W-1:0]   acc_next;

  // Next running sum: add the new sample, drop the evicted one (zero while filling)
  always_comb begin
    oldest     = (state == RUN) ? sample_buf[wr_ptr] : '0;
    in_ext     = {{LOG2_N{in_data[DATA_W-1]}}, in_data};
    oldest_ext = {{LOG2_N{oldest[DATA_W-1]}}, oldest};
    acc_next   = acc + in_ext - oldest_ext;
  end

  // Sample storage; never cleared, the fill state masks stale entries
  always_ff @(posedge clk) begin
    if (!reset && in_valid) begin
      sample_buf[wr_ptr] <= in_data;
    end
  end

  // Control, accumulator and registered outputs; the upper slice of the sum is the arithmetic shift by LOG2_N
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FILL;
      wr_ptr    <= '0;
      count     <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      wr_ptr    <= wr_ptr + LOG2_N'(1);
      acc       <= acc_next;
      out_data  <= acc_next[ACC_W-1:LOG2_N];
      out_valid <= 1'b1;
      if (state == FILL) begin
        count <= count + CNT_W'(1);
        if (count == LAST) begin
          state <= RUN;
        end
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

  assign primed = (state == RUN);

endmodule
